// File: rtl/reg_native_disp.sv
// reg_native_disp: routes one upstream register access to one of N_DS
// downstream windows by address, waits for that port's ack (bounded by a
// timeout) and returns a single-cycle upstream ack with data or error status.
module reg_native_disp #(
  parameter int                    ADDR_WIDTH  = 64,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    N_DS        = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WIN_BITS    = 12,
  parameter int                    TIMEOUT_CYC = 255,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA    = DATA_WIDTH'(32'hDEAD_BEEF)
) (
  input  logic                       fsm_clk,
  input  logic                       fsm_rstn,
  input  logic                       req_vld,
  input  logic                       wr_en,
  input  logic                       rd_en,
  input  logic [ADDR_WIDTH-1:0]      addr,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  output logic                       ack_vld,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic [N_DS-1:0]            ds_req_vld,
  output logic                       ds_wr_en,
  output logic                       ds_rd_en,
  output logic [ADDR_WIDTH-1:0]      ds_addr,
  output logic [DATA_WIDTH-1:0]      ds_wr_data,
  input  logic [N_DS-1:0]            ds_ack_vld,
  input  logic [N_DS*DATA_WIDTH-1:0] ds_rd_data,
  input  logic                       global_sync_reset_in,
  output logic                       err_vld,
  output logic [1:0]                 err_code,
  output logic                       busy
);

  localparam int IDX_W = (N_DS > 1) ? $clog2(N_DS) : 1;
  localparam int CNT_W = 16;
  localparam logic [ADDR_WIDTH-1:0] WIN_MASK = (ADDR_WIDTH'(1) << WIN_BITS) - ADDR_WIDTH'(1);

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_DECODE  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_FWD, S_WAIT, S_RESP} state_t;

  state_t                r_state;
  state_t                w_state_next;

  logic                  r_wr_en;
  logic                  r_rd_en;
  logic [ADDR_WIDTH-1:0] r_ds_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic [IDX_W-1:0]      r_idx;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_cap_data;
  logic [1:0]            r_err;
  logic                  r_ack_vld;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_err_vld;
  logic [1:0]            r_err_code;

  logic [ADDR_WIDTH-1:0] w_off;
  logic [ADDR_WIDTH-1:0] w_idx_full;
  logic                  w_dec_err;
  logic                  w_noop;
  logic                  w_ds_ack;
  logic [CNT_W-1:0]      w_cnt_inc;
  logic                  w_timeout;
  logic [DATA_WIDTH-1:0] w_ds_data [N_DS];

  // Address decode is evaluated on the live upstream inputs in IDLE.
  assign w_off      = addr - BASE_ADDR;
  assign w_idx_full = w_off >> WIN_BITS;
  assign w_dec_err  = (addr < BASE_ADDR) || (w_idx_full >= ADDR_WIDTH'(N_DS));
  assign w_noop     = !wr_en && !rd_en;

  // Only the selected port's ack counts; the counter "reaches" the limit on
  // the edge where its incremented value equals TIMEOUT_CYC.
  assign w_ds_ack  = ds_ack_vld[r_idx];
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_timeout = (w_cnt_inc == CNT_W'(TIMEOUT_CYC));

  genvar gi;
  generate
    for (gi = 0; gi < N_DS; gi++) begin : g_port
      assign w_ds_data[gi]  = ds_rd_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign ds_req_vld[gi] = (r_state == S_FWD) && (r_idx == IDX_W'(gi));
    end
  endgenerate

  // Downstream qualifiers pulse together with the request; address/data are held.
  assign ds_wr_en   = r_wr_en && (r_state == S_FWD);
  assign ds_rd_en   = r_rd_en && (r_state == S_FWD);
  assign ds_addr    = r_ds_addr;
  assign ds_wr_data = r_wr_data;

  assign ack_vld  = r_ack_vld;
  assign rd_data  = r_rd_data;
  assign err_vld  = r_err_vld;
  assign err_code = r_err_code;
  assign busy     = (r_state != S_IDLE);

  // State register: async hard reset, synchronous soft reset drops any transaction.
  always_ff @(posedge fsm_clk or negedge fsm_rstn) begin
    if (!fsm_rstn) begin
      r_state <= S_IDLE;
    end else if (global_sync_reset_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: no-ops and decode errors skip straight to the response.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (req_vld) w_state_next = (w_noop || w_dec_err) ? S_RESP : S_FWD;
      S_FWD:  w_state_next = S_WAIT;
      S_WAIT: if (w_ds_ack || w_timeout) w_state_next = S_RESP;
      S_RESP: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Request capture, timeout counter, response data and registered upstream outputs.
  always_ff @(posedge fsm_clk or negedge fsm_rstn) begin
    if (!fsm_rstn) begin
      r_wr_en    <= 1'b0;
      r_rd_en    <= 1'b0;
      r_ds_addr  <= '0;
      r_wr_data  <= '0;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_cap_data <= '0;
      r_err      <= ERR_NONE;
      r_ack_vld  <= 1'b0;
      r_rd_data  <= '0;
      r_err_vld  <= 1'b0;
      r_err_code <= ERR_NONE;
    end else if (global_sync_reset_in) begin
      r_wr_en    <= 1'b0;
      r_rd_en    <= 1'b0;
      r_ds_addr  <= '0;
      r_wr_data  <= '0;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_cap_data <= '0;
      r_err      <= ERR_NONE;
      r_ack_vld  <= 1'b0;
      r_rd_data  <= '0;
      r_err_vld  <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      r_ack_vld <= 1'b0;
      r_rd_data <= '0;
      r_err_vld <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_vld) begin
            r_wr_en    <= wr_en;
            r_rd_en    <= rd_en;
            r_ds_addr  <= w_off & WIN_MASK;
            r_wr_data  <= wr_data;
            r_idx      <= w_idx_full[IDX_W-1:0];
            r_cap_data <= '0;
            r_err      <= (!w_noop && w_dec_err) ? ERR_DECODE : ERR_NONE;
          end
        end
        S_FWD: begin
          r_cnt <= '0;
        end
        S_WAIT: begin
          r_cnt <= w_cnt_inc;
          if (w_ds_ack) begin
            r_cap_data <= w_ds_data[r_idx];
          end else if (w_timeout) begin
            r_err <= ERR_TIMEOUT;
          end
        end
        S_RESP: begin
          r_ack_vld <= 1'b1;
          r_rd_data <= (r_err != ERR_NONE) ? ERR_DATA : r_cap_data;
          r_err_vld <= (r_err != ERR_NONE);
          if (r_err != ERR_NONE) r_err_code <= r_err;
        end
        default: ;
      endcase
    end
  end

endmodule
